// File: rtl/sram_resp_timer.sv
// Multi-channel fixed-latency SRAM response timer.
// Every channel tracks up to DEPTH outstanding requests. It answers each accepted request with a
// one-cycle resp pulse exactly L cycles after acceptance. Only one latency may be in flight per
// channel at a time, so responses stay in order and at most one completes per cycle.
module sram_resp_timer #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned MAX_LAT = 4,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned LAT_W   = $clog2(MAX_LAT + 1),
    parameter int unsigned PEND_W  = $clog2(DEPTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_CH-1:0]          req_i,
    input  logic [NUM_CH*LAT_W-1:0]    lat_cfg_i,
    input  logic [NUM_CH-1:0]          flush_i,
    input  logic [NUM_CH-1:0]          err_clr_i,
    output logic [NUM_CH-1:0]          req_rdy_o,
    output logic [NUM_CH-1:0]          resp_o,
    output logic [NUM_CH-1:0]          busy_o,
    output logic [NUM_CH*PEND_W-1:0]   pending_o,
    output logic [NUM_CH-1:0]          drop_err_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DEPTH-1:0]            valid_q, valid_d;
        logic [DEPTH-1:0][LAT_W-1:0] cnt_q, cnt_d;
        logic [LAT_W-1:0]            lat_q, lat_d, lat_eff;
        logic [PEND_W-1:0]           pend_q, pend_d;
        logic                        resp_q, resp_d;
        logic                        busy_q, busy_d;
        logic                        err_q, err_d;
        logic                        rdy, accept, refuse, done, loaded;

        // Clamp the requested latency into 1..MAX_LAT.
        always_comb begin
            lat_eff = lat_cfg_i[c*LAT_W +: LAT_W];
            if (lat_eff == '0) begin
                lat_eff = LAT_W'(1);
            end else if (lat_eff > LAT_W'(MAX_LAT)) begin
                lat_eff = LAT_W'(MAX_LAT);
            end
        end

        // A slot whose counter is at 1 still counts as occupied this cycle (no bypass).
        assign rdy    = (pend_q < PEND_W'(DEPTH)) && ((pend_q == '0) || (lat_eff == lat_q))
                        && !flush_i[c];
        assign accept = req_i[c] && rdy;
        assign refuse = req_i[c] && !rdy && !flush_i[c];

        // Slot countdown, allocation and registered response generation.
        always_comb begin
            valid_d = valid_q;
            cnt_d   = cnt_q;
            lat_d   = lat_q;
            done    = 1'b0;
            resp_d  = 1'b0;
            loaded  = 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                if (valid_q[s]) begin
                    if (cnt_q[s] == LAT_W'(1)) begin
                        valid_d[s] = 1'b0;
                        done       = 1'b1;
                    end else begin
                        cnt_d[s] = cnt_q[s] - LAT_W'(1);
                        // Counter reaches 1 next cycle: that is the cycle resp must be high.
                        if ({1'b0, cnt_q[s]} == (LAT_W + 1)'(2)) begin
                            resp_d = 1'b1;
                        end
                    end
                end
            end
            if (accept) begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (!loaded && !valid_q[s]) begin
                        valid_d[s] = 1'b1;
                        cnt_d[s]   = lat_eff;
                        loaded     = 1'b1;
                    end
                end
                lat_d = lat_eff;
                if (lat_eff == LAT_W'(1)) begin
                    resp_d = 1'b1;
                end
            end
            // Flush discards everything, including a pulse that would appear next cycle.
            if (flush_i[c]) begin
                valid_d = '0;
                resp_d  = 1'b0;
            end
        end

        // Outstanding count, busy and sticky drop error.
        always_comb begin
            pend_d = pend_q;
            unique case ({accept, done})
                2'b10:   pend_d = pend_q + PEND_W'(1);
                2'b01:   pend_d = pend_q - PEND_W'(1);
                default: pend_d = pend_q;
            endcase
            if (flush_i[c]) begin
                pend_d = '0;
            end
            busy_d = (pend_d != '0);
            err_d  = err_q;
            if (err_clr_i[c]) begin
                err_d = 1'b0;
            end
            if (refuse) begin
                err_d = 1'b1;
            end
        end

        // State registers with asynchronous active-low reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= '0;
                cnt_q   <= '0;
                lat_q   <= LAT_W'(1);
                pend_q  <= '0;
                resp_q  <= 1'b0;
                busy_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                valid_q <= valid_d;
                cnt_q   <= cnt_d;
                lat_q   <= lat_d;
                pend_q  <= pend_d;
                resp_q  <= resp_d;
                busy_q  <= busy_d;
                err_q   <= err_d;
            end
        end

        assign req_rdy_o[c]                  = rdy;
        assign resp_o[c]                     = resp_q;
        assign busy_o[c]                     = busy_q;
        assign pending_o[c*PEND_W +: PEND_W] = pend_q;
        assign drop_err_o[c]                 = err_q;
    end

endmodule

// File: tb/tb_sram_resp_timer.sv
// Self-checking bench for sram_resp_timer (NUM_CH=2, MAX_LAT=4, DEPTH=2).
// The reference model keeps a list of absolute due cycles for each outstanding request.
module tb_sram_resp_timer;
    localparam int NUM_CH = 2;
    localparam int MAX_LAT = 4;
    localparam int DEPTH = 2;
    localparam int LAT_W = 3;
    localparam int PEND_W = 2;

    logic clk, rst_n;
    logic [1:0] req, flush, err_clr;
    logic [5:0] lat_cfg;
    logic [1:0] req_rdy, resp, busy, drop_err;
    logic [3:0] pending;

    sram_resp_timer #(
        .NUM_CH (NUM_CH),
        .MAX_LAT(MAX_LAT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .lat_cfg_i (lat_cfg),
        .flush_i   (flush),
        .err_clr_i (err_clr),
        .req_rdy_o (req_rdy),
        .resp_o    (resp),
        .busy_o    (busy),
        .pending_o (pending),
        .drop_err_o(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ch;
        int due;
    } ent_t;
    ent_t outst[$];
    int   mlat[2];
    bit   merr[2];
    int   cyc = 0;

    logic [1:0] obs_rdy, obs_resp, obs_err;
    int obs_pend[2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int eff_lat(input int v);
        if (v == 0) return 1;
        if (v > MAX_LAT) return MAX_LAT;
        return v;
    endfunction

    function automatic int model_pend(input int c);
        int n = 0;
        foreach (outst[i]) if (outst[i].ch == c) n++;
        return n;
    endfunction

    function automatic bit model_resp(input int c);
        foreach (outst[i]) if (outst[i].ch == c && outst[i].due == cyc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        outst.delete();
        for (int c = 0; c < 2; c++) begin
            mlat[c] = 1;
            merr[c] = 1'b0;
        end
    endtask

    // One clock cycle: entered just after a rising edge, leaves just after the next one.
    task automatic cycle(input logic [1:0] rq, input logic [5:0] lat, input logic [1:0] fl,
                         input logic [1:0] cl);
        ent_t keep[$];
        bit   e_rdy[2];
        bit   e_resp[2];
        int   e_pend[2];
        int   l[2];
        req = rq; lat_cfg = lat; flush = fl; err_clr = cl;
        foreach (outst[i]) if (outst[i].due >= cyc) keep.push_back(outst[i]);
        outst = keep;
        for (int c = 0; c < 2; c++) begin
            l[c]      = eff_lat(int'(lat[c*LAT_W +: LAT_W]));
            e_pend[c] = model_pend(c);
            e_resp[c] = model_resp(c);
            e_rdy[c]  = (e_pend[c] < DEPTH) && (e_pend[c] == 0 || l[c] == mlat[c]) && !fl[c];
        end
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            obs_rdy[c]  = req_rdy[c];
            obs_resp[c] = resp[c];
            obs_err[c]  = drop_err[c];
            obs_pend[c] = int'(pending[c*PEND_W +: PEND_W]);
            chk($sformatf("req_rdy[%0d]", c), int'(req_rdy[c]), int'(e_rdy[c]));
            chk($sformatf("resp[%0d]", c), int'(resp[c]), int'(e_resp[c]));
            chk($sformatf("pending[%0d]", c), obs_pend[c], e_pend[c]);
            chk($sformatf("busy[%0d]", c), int'(busy[c]), int'(e_pend[c] != 0));
            chk($sformatf("drop_err[%0d]", c), int'(drop_err[c]), int'(merr[c]));
        end
        for (int c = 0; c < 2; c++) begin
            bit refused;
            refused = rq[c] && !e_rdy[c] && !fl[c];
            if (fl[c]) begin
                keep.delete();
                foreach (outst[i]) if (outst[i].ch != c) keep.push_back(outst[i]);
                outst = keep;
            end else if (rq[c] && e_rdy[c]) begin
                outst.push_back('{c, cyc + l[c]});
                mlat[c] = l[c];
            end
            if (cl[c]) merr[c] = 1'b0;
            if (refused) merr[c] = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        cycle(2'b00, 6'd0, 2'b00, 2'b00);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        req = '0; flush = '0; err_clr = '0; lat_cfg = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst resp", int'(resp), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst pending", int'(pending), 0);
        chk("rst drop_err", int'(drop_err), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // Issue one request on a channel and measure cycles until its resp (bounded).
    task automatic measure(input int c, input logic [2:0] lv, input int exp);
        logic [5:0] lat;
        int got = -1;
        lat = '0;
        lat[c*LAT_W +: LAT_W] = lv;
        cycle(2'(1 << c), lat, 2'b00, 2'b00);
        for (int k = 1; k <= 8; k++) begin
            idle();
            if (obs_resp[c] && got < 0) got = k;
        end
        chk($sformatf("latency ch%0d cfg=%0d", c, lv), got, exp);
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] clr;
        logic [1:0] rdy;
        logic [1:0] resp;
        int         p0;
        int         p1;
        logic [1:0] err;
    } vec_t;
    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int got;
        int cnt;
        logic [1:0] rq, fl, cl;
        logic [5:0] lat;
        logic [2:0] keep_lat[2];

        // cycle: req, err_clr, exp req_rdy, exp resp, exp pending0, exp pending1, exp drop_err
        // ch0 at L=1, ch1 at L=2.
        tbl[0]  = '{2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 2'b00};
        tbl[1]  = '{2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 2'b00};
        tbl[2]  = '{2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 2'b00};
        tbl[3]  = '{2'b10, 2'b00, 2'b11, 2'b00, 0, 0, 2'b00};
        tbl[4]  = '{2'b10, 2'b00, 2'b11, 2'b00, 0, 1, 2'b00};
        tbl[5]  = '{2'b11, 2'b00, 2'b01, 2'b10, 0, 2, 2'b00};
        tbl[6]  = '{2'b00, 2'b00, 2'b11, 2'b11, 1, 1, 2'b10};
        tbl[7]  = '{2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 2'b10};
        tbl[8]  = '{2'b00, 2'b10, 2'b11, 2'b00, 0, 0, 2'b10};
        tbl[9]  = '{2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 2'b00};
        tbl[10] = '{2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 2'b00};

        rst_n = 1'b1;
        #1;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].req, {3'd2, 3'd1}, 2'b00, tbl[i].clr);
            chk($sformatf("tbl%0d req_rdy", i), int'(obs_rdy), int'(tbl[i].rdy));
            chk($sformatf("tbl%0d resp", i), int'(obs_resp), int'(tbl[i].resp));
            chk($sformatf("tbl%0d pending0", i), obs_pend[0], tbl[i].p0);
            chk($sformatf("tbl%0d pending1", i), obs_pend[1], tbl[i].p1);
            chk($sformatf("tbl%0d drop_err", i), int'(obs_err), int'(tbl[i].err));
        end

        // Clamping: 0 acts as 1, 7 is clamped to MAX_LAT.
        measure(0, 3'd0, 1);
        measure(1, 3'd7, 4);
        measure(0, 3'd3, 3);

        // Mixed latency refused while L=3 is outstanding; first resp still at n+3.
        cycle(2'b01, {3'd0, 3'd3}, 2'b00, 2'b00);
        got = -1;
        for (int k = 1; k <= 6; k++) begin
            if (k == 1) begin
                cycle(2'b01, {3'd0, 3'd2}, 2'b00, 2'b00);
                chk("mixed lat req_rdy", int'(obs_rdy[0]), 0);
            end else begin
                idle();
            end
            if (k == 2) chk("mixed lat drop_err", int'(obs_err[0]), 1);
            if (obs_resp[0] && got < 0) got = k;
        end
        chk("mixed lat first resp", got, 3);
        cycle(2'b00, 6'd0, 2'b00, 2'b01);
        idle();
        chk("err_clr drop_err", int'(obs_err[0]), 0);

        // Flush two L=4 requests on ch0 while ch1 streams L=1 requests.
        cycle(2'b11, {3'd1, 3'd4}, 2'b00, 2'b00);
        cycle(2'b11, {3'd1, 3'd4}, 2'b00, 2'b00);
        cycle(2'b11, {3'd1, 3'd4}, 2'b01, 2'b00);
        chk("flush req_rdy", int'(obs_rdy[0]), 0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(2'b10, {3'd1, 3'd0}, 2'b00, 2'b00);
            if (k == 0) begin
                chk("flush pending", obs_pend[0], 0);
                chk("flush no drop_err", int'(obs_err[0]), 0);
            end
            cnt += int'(obs_resp[0]);
        end
        chk("flush resp count", cnt, 0);
        idle();

        // Reset mid-flight with a drop error latched on ch1.
        cycle(2'b11, {3'd4, 3'd4}, 2'b00, 2'b00);
        cycle(2'b11, {3'd4, 3'd4}, 2'b00, 2'b00);
        cycle(2'b10, {3'd4, 3'd4}, 2'b00, 2'b00);
        do_reset();
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            idle();
            cnt += int'(obs_resp[0]) + int'(obs_resp[1]);
        end
        chk("post-reset resp count", cnt, 0);

        // Randomised traffic on both channels against the model.
        keep_lat[0] = 3'd2;
        keep_lat[1] = 3'd3;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 3) == 0) keep_lat[c] = 3'($urandom_range(0, 7));
                rq[c] = ($urandom_range(0, 1) == 1);
                fl[c] = ($urandom_range(0, 15) == 0);
                cl[c] = ($urandom_range(0, 7) == 0);
            end
            lat = {keep_lat[1], keep_lat[0]};
            cycle(rq, lat, fl, cl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
